// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Channel-select width, never narrower than one bit so N_CH=1 still has a port.
  function automatic int CH_IDX_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and up / up-down timebase; flags the commit cycle (tick && wrap).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  pwm_mode_e          mode_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [CNT_W-1:0]   period_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               commit_o,
  output logic               period_end_o
);

  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_down_q, dir_down_d;
  logic               period_end_q;
  logic               tick, wrap;

  always_comb begin
    tick        = en_i && (presc_cnt_q >= presc_i);
    wrap        = 1'b0;
    cnt_d       = cnt_q;
    dir_down_d  = dir_down_q;
    presc_cnt_d = tick ? '0 : presc_cnt_q + P_ONE;

    if (tick) begin
      if (mode_i == PWM_EDGE) begin
        dir_down_d = 1'b0;
        if (cnt_q >= period_i) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end else if (!dir_down_q) begin
        // A zero period in centre mode degenerates to a wrap on every tick.
        if (period_i == '0) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else if (cnt_q >= period_i) begin
          dir_down_d = 1'b1;
          cnt_d      = cnt_q - C_ONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end else if (cnt_q == '0) begin
        dir_down_d = 1'b0;
        cnt_d      = C_ONE;
        wrap       = 1'b1;
      end else begin
        cnt_d = cnt_q - C_ONE;
      end
    end

    if (!en_i) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_down_d  = 1'b0;
    end
  end

  assign commit_o = tick && wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q  <= '0;
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      presc_cnt_q  <= presc_cnt_d;
      cnt_q        <= cnt_d;
      dir_down_q   <= dir_down_d;
      period_end_q <= commit_o;
    end
  end

  assign cnt_o        = cnt_q;
  assign period_end_o = period_end_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: double-buffered duty registers committed at period boundaries.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [PRESC_W-1:0]        presc,
  input  logic [CNT_W-1:0]          period,
  input  logic                      duty_wr_valid,
  output logic                      duty_wr_ready,
  input  logic [CH_IDX_W(N_CH)-1:0] duty_wr_ch,
  input  logic [CNT_W-1:0]          duty_wr_data,
  output logic [N_CH-1:0]           pwm_out,
  output logic                      period_end
);

  localparam int CH_W = CH_IDX_W(N_CH);

  pwm_mode_e        mode_e;
  logic [CNT_W-1:0] cnt;
  logic             commit;
  logic             wr_fire;
  logic             load;

  logic [CNT_W-1:0] shadow_q [N_CH];
  logic [CNT_W-1:0] shadow_d [N_CH];
  logic [CNT_W-1:0] active_q [N_CH];
  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  pwm_q;

  assign mode_e = pwm_mode_e'(mode);

  pwm_timebase #(
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .mode_i      (mode_e),
    .presc_i     (presc),
    .period_i    (period),
    .cnt_o       (cnt),
    .commit_o    (commit),
    .period_end_o(period_end)
  );

  // Stalling writes only in the commit cycle keeps shadow and active coherent.
  assign duty_wr_ready = !commit;
  assign wr_fire       = duty_wr_valid && duty_wr_ready;
  assign load          = !en || commit;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire && (duty_wr_ch == CH_W'(i))) shadow_d[i] = duty_wr_data;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cmp
    assign hit[g] = cnt < active_q[g];
  end

  // Loading from shadow_d lets a write in the last idle cycle reach the first period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      pwm_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (load) active_q <= shadow_d;
      pwm_q <= en ? hit : '0;
    end
  end

  assign pwm_out = pwm_q;

endmodule
